// File: rtl/heartbeat_pkg.sv
// Shared constants and helpers for the heartbeat peripheral: register map,
// response codes and byte-strobe merging.
package heartbeat_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_HIGH    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int unsigned CTRL_EN_BIT = 0;

  // Byte i of the result comes from new_val when strb[i] is set, else from old_val.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/heartbeat_axi_slave_if.sv
// AXI4-Lite bus bundle between the interconnect master and the heartbeat
// register slave.
interface heartbeat_axi_slave_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/heartbeat_gen.sv
// LED heartbeat generator: a free-running counter modulo PERIOD with the
// output high while the count is below HIGH.
module heartbeat_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [31:0] high,
  input  logic        period_wr,
  output logic        heartbeat
);

  logic [31:0] cnt_q, cnt_d;
  logic        heartbeat_q, heartbeat_d;
  logic        active;

  always_comb begin
    active      = enable && (period != '0);
    cnt_d       = '0;
    // The >= form also recovers in one cycle when PERIOD shrinks below cnt.
    if (active && !period_wr && (cnt_q < period - 32'd1)) begin
      cnt_d = cnt_q + 32'd1;
    end
    heartbeat_d = active && (cnt_q < high);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      heartbeat_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      heartbeat_q <= heartbeat_d;
    end
  end

  assign heartbeat = heartbeat_q;

endmodule

// File: rtl/heartbeat_axi_slave.sv
// AXI4-Lite register file (CTRL, PERIOD, HIGH, SCRATCH) with single-outstanding
// read and write channels, driving the heartbeat generator.
module heartbeat_axi_slave
  import heartbeat_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  heartbeat_axi_slave_if.slave s_axi,
  output logic                 HEARTBEAT
);

  typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

  word_t [3:0] regs_q, regs_d;
  word_t       rdata_q, rdata_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  wsel, rsel;
  logic        period_wr;
  logic        unused_bits;

  assign wsel = s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rsel = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT,
                         s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  always_comb begin
    // AW and W are only accepted as a pair; the READY pulse is cycle N+1.
    awready_d = s_axi.AWVALID && s_axi.WVALID && !awready_q && !bvalid_q;
    bvalid_d  = bvalid_q;
    if (awready_q) bvalid_d = 1'b1;
    else if (bvalid_q && s_axi.BREADY) bvalid_d = 1'b0;

    regs_d = regs_q;
    if (awready_q) begin
      regs_d[wsel] = apply_wstrb(regs_q[wsel], s_axi.WDATA, s_axi.WSTRB);
    end
    period_wr = awready_q && (wsel == REG_PERIOD) && (s_axi.WSTRB != '0);

    // RDATA samples regs_q, so a same-cycle write to that register is not seen.
    arready_d = s_axi.ARVALID && !arready_q && !rvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[rsel];
    end else if (rvalid_q && s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q    <= '0;
      rdata_q   <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      rdata_q   <= rdata_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = awready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = RESP_OKAY;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = RESP_OKAY;

  heartbeat_gen u_gen (
    .clk       (ACLK),
    .rst       (ARESET),
    .enable    (regs_q[REG_CTRL][CTRL_EN_BIT]),
    .period    (regs_q[REG_PERIOD]),
    .high      (regs_q[REG_HIGH]),
    .period_wr (period_wr),
    .heartbeat (HEARTBEAT)
  );

endmodule

// File: tb/tb_heartbeat_axi_slave.sv
// Self-checking bench for heartbeat_axi_slave: vector table plus hand-written
// handshake, backpressure, heartbeat and reset sequences.
module tb_heartbeat_axi_slave;
  import heartbeat_pkg::*;

  localparam int unsigned TMO = 64;
  localparam int unsigned S_AWREADY = 0;
  localparam int unsigned S_BVALID  = 1;
  localparam int unsigned S_ARREADY = 2;
  localparam int unsigned S_RVALID  = 3;

  logic clk = 1'b0;
  logic rst;
  logic hb;
  always #5 clk = ~clk;

  heartbeat_axi_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  heartbeat_axi_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .s_axi     (bus),
    .HEARTBEAT (hb)
  );

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] rd_exp_q [$];
  logic [1:0]  b_exp_q [$];
  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out, got 0 want 1", name);
  endtask

  function automatic logic sig_of(input int unsigned which);
    case (which)
      S_AWREADY: return bus.AWREADY;
      S_BVALID:  return bus.BVALID;
      S_ARREADY: return bus.ARREADY;
      default:   return bus.RVALID;
    endcase
  endfunction

  task automatic wait_high(input int unsigned which, input string name);
    int unsigned n = 0;
    while (sig_of(which) !== 1'b1 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    if (sig_of(which) !== 1'b1) timeout_fail(name);
  endtask

  task automatic finish_b(input string name);
    wait_high(S_BVALID, {name, "_bvalid"});
    if (b_exp_q.size() == 0) timeout_fail({name, "_b_scoreboard"});
    else check({name, "_bresp"}, 32'(bus.BRESP), 32'(b_exp_q.pop_front()));
    @(posedge clk); #1;
  endtask

  task automatic finish_r(input string name);
    wait_high(S_RVALID, {name, "_rvalid"});
    if (rd_exp_q.size() == 0) timeout_fail({name, "_r_scoreboard"});
    else check({name, "_rdata"}, bus.RDATA, rd_exp_q.pop_front());
    check({name, "_rresp"}, 32'(bus.RRESP), 32'(RESP_OKAY));
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    b_exp_q.push_back(RESP_OKAY);
    wait_high(S_AWREADY, "wr_awready");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    finish_b("wr");
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    rd_exp_q.push_back(exp);
    wait_high(S_ARREADY, {name, "_arready"});
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    finish_r(name);
  endtask

  task automatic wait_rise(input string name);
    int unsigned n = 0;
    logic prev;
    prev = hb;
    @(posedge clk); #1;
    while (!(prev === 1'b0 && hb === 1'b1) && n < TMO) begin
      prev = hb;
      @(posedge clk); #1;
      n++;
    end
    if (!(prev === 1'b0 && hb === 1'b1)) timeout_fail(name);
  endtask

  task automatic check_pattern(input string name, input int unsigned p, input int unsigned h,
                               input int unsigned cycles);
    for (int unsigned k = 0; k < cycles; k++) begin
      check($sformatf("%s_%0d", name, k), 32'(hb), ((k % p) < h) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 32'h0101FFFF, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 4'h4, 32'habcd0001, 4'hF, 32'h0};
    vecs[2]  = '{1'b1, 4'h8, 32'hdead0011, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 4'hC, 32'hbeef0011, 4'hF, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0101FFFF};
    vecs[5]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'habcd0001};
    vecs[6]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'hdead0011};
    vecs[7]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'hbeef0011};
    vecs[8]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 4'hC, 32'h12345678, 4'b0101, 32'h0};
    vecs[10] = '{1'b0, 4'hC, 32'h0,        4'h0, 32'hFF34FF78};

    rst = 1'b1;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(bus.AWREADY), 32'd0);
    check("rst_wready",  32'(bus.WREADY),  32'd0);
    check("rst_bvalid",  32'(bus.BVALID),  32'd0);
    check("rst_bresp",   32'(bus.BRESP),   32'd0);
    check("rst_arready", 32'(bus.ARREADY), 32'd0);
    check("rst_rvalid",  32'(bus.RVALID),  32'd0);
    check("rst_rdata",   bus.RDATA,        32'd0);
    check("rst_rresp",   32'(bus.RRESP),   32'd0);
    check("rst_hb",      32'(hb),          32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else axi_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Read and write to PERIOD in the same cycle: read sees the old value.
    fork
      axi_write(4'h4, 32'h00000077, 4'hF);
      axi_read(4'h4, 32'habcd0001, "same_cycle_rw");
    join
    axi_read(4'h4, 32'h00000077, "after_rw");

    // Write backpressure: B held, second AW+W waits.
    bus.BREADY = 1'b0;
    bus.AWADDR = 4'h8; bus.WDATA = 32'h00001111; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    b_exp_q.push_back(RESP_OKAY);
    wait_high(S_AWREADY, "bp_awready");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    wait_high(S_BVALID, "bp_bvalid");
    check("bp_bresp", 32'(bus.BRESP), 32'(b_exp_q.pop_front()));
    bus.AWADDR = 4'hC; bus.WDATA = 32'h5A5A0000;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    b_exp_q.push_back(RESP_OKAY);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_bvalid_held", 32'(bus.BVALID), 32'd1);
      check("bp_awready_blocked", 32'({bus.AWREADY, bus.WREADY}), 32'd0);
    end
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    check("bp_bvalid_drop", 32'(bus.BVALID), 32'd0);
    wait_high(S_AWREADY, "bp_second_awready");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    finish_b("bp_second");
    axi_read(4'h8, 32'h00001111, "bp_rd_high");
    axi_read(4'hC, 32'h5A5A0000, "bp_rd_scratch");

    // Read backpressure: RDATA stable, a second AR waits.
    bus.RREADY = 1'b0;
    bus.ARADDR = 4'hC; bus.ARVALID = 1'b1;
    wait_high(S_ARREADY, "rbp_arready");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    wait_high(S_RVALID, "rbp_rvalid");
    bus.ARADDR = 4'h0; bus.ARVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("rbp_rvalid_held", 32'(bus.RVALID), 32'd1);
      check("rbp_rdata_stable", bus.RDATA, 32'h5A5A0000);
      check("rbp_arready_blocked", 32'(bus.ARREADY), 32'd0);
    end
    bus.RREADY = 1'b1;
    @(posedge clk); #1;
    check("rbp_rvalid_drop", 32'(bus.RVALID), 32'd0);
    rd_exp_q.push_back(32'h0101FFFF);
    wait_high(S_ARREADY, "rbp_second_arready");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    finish_r("rbp_second");

    // Split channels: AW leads W by three cycles.
    bus.AWADDR = 4'h0; bus.WDATA = 32'h00000100; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("split_wait_ready", 32'({bus.AWREADY, bus.WREADY}), 32'd0);
    end
    bus.WVALID = 1'b1;
    b_exp_q.push_back(RESP_OKAY);
    @(posedge clk); #1;
    check("split_ready_pulse", 32'({bus.AWREADY, bus.WREADY}), 32'd3);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("split_ready_one_cycle", 32'({bus.AWREADY, bus.WREADY}), 32'd0);
    finish_b("split");
    axi_read(4'h0, 32'h00000100, "split_rd");

    // Heartbeat patterns.
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    wait_rise("hb_rise_p10");
    check_pattern("hb_p10", 10, 3, 20);
    axi_write(4'h4, 32'd4, 4'hF);
    wait_rise("hb_rise_p4");
    check_pattern("hb_p4", 4, 3, 12);
    axi_write(4'h8, 32'd4, 4'hF);
    repeat (3) begin @(posedge clk); #1; end
    check_pattern("hb_high_ge_period", 4, 4, 8);
    axi_write(4'h0, 32'd0, 4'hF);
    check("hb_ctrl_off", 32'(hb), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    check("hb_ctrl_off_hold", 32'(hb), 32'd0);

    // Reset while a read response is pending.
    axi_write(4'h8, 32'd2, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    bus.RREADY = 1'b0;
    bus.ARADDR = 4'hC; bus.ARVALID = 1'b1;
    wait_high(S_ARREADY, "mid_rst_arready");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    wait_high(S_RVALID, "mid_rst_rvalid");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_rvalid_drop", 32'(bus.RVALID), 32'd0);
    check("mid_rst_rdata", bus.RDATA, 32'd0);
    check("mid_rst_hb", 32'(hb), 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 32'd0, $sformatf("post_rst_reg%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
